// File: rtl/mips_pkg.sv
// Shared constants and types for the multi-cycle MIPS sequencer.
// Holds opcode/funct codes, the FSM state set, ALU and PC-source selectors.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] FN_ADD   = 6'b100000;

  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;

  localparam logic [1:0] PC_SEQ = 2'b00;
  localparam logic [1:0] PC_BR  = 2'b01;
  localparam logic [1:0] PC_JMP = 2'b10;

  typedef enum logic [2:0] {
    FETCH, DECODE, EXEC, MEM, WB, TRAP
  } state_e;

  typedef struct packed {
    logic is_add;
    logic is_addi;
    logic is_lw;
    logic is_sw;
    logic is_j;
    logic is_beq;
    logic is_bne;
    logic is_illegal;
  } iclass_t;

endpackage

// File: rtl/mips_multicycle_ctrl_if.sv
// Controller <-> datapath/memory bundle for the multi-cycle MIPS core.
// master = sequencer, slave = datapath and unified memory.
interface mips_ctrl_if #(
  parameter int SIZE = 32
);
  logic [SIZE-1:0] mem_rdata;
  logic            mem_ready;
  logic            zero;
  logic [SIZE-1:0] ir;
  logic            IorD;
  logic            MemRead;
  logic            MemWrite;
  logic            IRWrite;
  logic            PCen;
  logic [1:0]      PCSrc;
  logic            ALUSrc;
  logic [3:0]      ALUOp;
  logic            RegDst;
  logic            MemToReg;
  logic            RegWrite;
  logic            retire;
  logic            illegal;

  modport master (
    input  mem_rdata, mem_ready, zero,
    output ir, IorD, MemRead, MemWrite, IRWrite,
    output PCen, PCSrc, ALUSrc, ALUOp, RegDst,
    output MemToReg, RegWrite, retire, illegal
  );

  modport slave (
    output mem_rdata, mem_ready, zero,
    input  ir, IorD, MemRead, MemWrite, IRWrite,
    input  PCen, PCSrc, ALUSrc, ALUOp, RegDst,
    input  MemToReg, RegWrite, retire, illegal
  );
endinterface

// File: rtl/mips_inst_class.sv
// Combinational instruction classifier: opcode/funct -> one-hot class.
// Anything outside the supported subset is flagged illegal.
module mips_inst_class
  import mips_pkg::*;
(
  input  logic [5:0] op_i,
  input  logic [5:0] fn_i,
  output iclass_t    cls_o
);

  always_comb begin
    cls_o = '0;
    case (op_i)
      OP_RTYPE: cls_o.is_add  = (fn_i == FN_ADD);
      OP_ADDI:  cls_o.is_addi = 1'b1;
      OP_LW:    cls_o.is_lw   = 1'b1;
      OP_SW:    cls_o.is_sw   = 1'b1;
      OP_J:     cls_o.is_j    = 1'b1;
      OP_BEQ:   cls_o.is_beq  = 1'b1;
      OP_BNE:   cls_o.is_bne  = 1'b1;
      default:  ;
    endcase
    cls_o.is_illegal = ~|{cls_o.is_add, cls_o.is_addi,
                          cls_o.is_lw, cls_o.is_sw,
                          cls_o.is_j, cls_o.is_beq,
                          cls_o.is_bne};
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS sequencer: owns IR, steps FETCH..WB,
// decodes datapath strobes from state, IR class, mem_ready and zero.
module mips_multicycle_ctrl
  import mips_pkg::*;
#(
  parameter int SIZE = 32
) (
  input logic       clk,
  input logic       rst,
  mips_ctrl_if.master bus
);

  state_e          state_q, state_d;
  logic [SIZE-1:0] ir_q;
  logic            run_q;
  logic            ir_we;
  iclass_t         cls;

  mips_inst_class u_cls (
    .op_i  (ir_q[31:26]),
    .fn_i  (ir_q[5:0]),
    .cls_o (cls)
  );

  // run_q keeps every strobe quiet for the first cycle out of reset
  assign ir_we = run_q && (state_q == FETCH) && bus.mem_ready;
  assign bus.ir = ir_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FETCH:  if (ir_we) state_d = DECODE;
      DECODE: state_d = cls.is_illegal ? TRAP : EXEC;
      EXEC: begin
        unique case (1'b1)
          cls.is_add, cls.is_addi: state_d = WB;
          cls.is_lw, cls.is_sw:    state_d = MEM;
          default:                 state_d = FETCH;
        endcase
      end
      MEM: if (bus.mem_ready) state_d = cls.is_lw ? WB : FETCH;
      WB:      state_d = FETCH;
      TRAP:    state_d = TRAP;
      default: state_d = FETCH;
    endcase
  end

  always_comb begin
    bus.IorD     = 1'b0;
    bus.MemRead  = 1'b0;
    bus.MemWrite = 1'b0;
    bus.IRWrite  = 1'b0;
    bus.PCen     = 1'b0;
    bus.PCSrc    = PC_SEQ;
    bus.ALUSrc   = 1'b0;
    bus.ALUOp    = 4'b0000;
    bus.RegDst   = 1'b0;
    bus.MemToReg = 1'b0;
    bus.RegWrite = 1'b0;
    bus.retire   = 1'b0;
    bus.illegal  = 1'b0;
    unique case (state_q)
      FETCH: begin
        bus.MemRead = run_q;
        bus.IRWrite = ir_we;
        bus.PCen    = ir_we;
      end
      EXEC: begin
        unique case (1'b1)
          cls.is_add: bus.ALUOp = ALU_ADD;
          cls.is_addi, cls.is_lw, cls.is_sw: begin
            bus.ALUSrc = 1'b1;
            bus.ALUOp  = ALU_ADD;
          end
          cls.is_beq, cls.is_bne: begin
            bus.ALUOp  = ALU_SUB;
            bus.PCSrc  = PC_BR;
            bus.PCen   = cls.is_beq ? bus.zero : ~bus.zero;
            bus.retire = 1'b1;
          end
          cls.is_j: begin
            bus.PCSrc  = PC_JMP;
            bus.PCen   = 1'b1;
            bus.retire = 1'b1;
          end
          default: ;
        endcase
      end
      MEM: begin
        bus.IorD     = 1'b1;
        bus.MemRead  = cls.is_lw;
        bus.MemWrite = cls.is_sw;
        bus.retire   = cls.is_sw & bus.mem_ready;
      end
      WB: begin
        bus.RegWrite = 1'b1;
        bus.retire   = 1'b1;
        bus.RegDst   = cls.is_add;
        bus.MemToReg = cls.is_lw;
      end
      TRAP:    bus.illegal = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FETCH;
      ir_q    <= '0;
      run_q   <= 1'b0;
    end else begin
      run_q   <= 1'b1;
      state_q <= state_d;
      if (ir_we) ir_q <= bus.mem_rdata;
    end
  end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Bench for mips_multicycle_ctrl: instruction-level plans expand to
// per-cycle expectations, replayed against the DUT one cycle at a time.
module tb_mips_multicycle_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mips_ctrl_if #(.SIZE(32)) bus ();

  mips_multicycle_ctrl #(.SIZE(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef enum int {K_ADD, K_ADDI, K_LW, K_SW, K_J, K_BEQ, K_BNE, K_ILL} kind_e;

  typedef struct packed {
    logic        rdy;
    logic [31:0] rdata;
    logic        zero;
    logic [31:0] ir;
    logic        mr, mw, irw, pcen, rw, ret, ill, iord;
    logic [1:0]  pcsrc;
    logic        alusrc;
    logic [3:0]  aluop;
    logic        regdst, m2r;
    logic        c_iord, c_pc, c_alu, c_wb;
    logic        rst_after;
  } cyc_t;

  cyc_t        q[$];
  logic [31:0] cur_ir = 32'h0;
  int          n_cmp = 0;
  int          n_fail = 0;
  int          idx = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d t=%0t got=%h want=%h",
               nm, idx, $time, act, exp);
    end
  endtask

  function automatic kind_e kind_of(input logic [31:0] w);
    case (w[31:26])
      6'd0:  return (w[5:0] == 6'h20) ? K_ADD : K_ILL;
      6'd8:  return K_ADDI;
      6'd35: return K_LW;
      6'd43: return K_SW;
      6'd2:  return K_J;
      6'd4:  return K_BEQ;
      6'd5:  return K_BNE;
      default: return K_ILL;
    endcase
  endfunction

  function automatic cyc_t blank();
    cyc_t r;
    r = '0;
    r.ir = cur_ir;
    r.rdy = 1'($urandom);
    r.rdata = $urandom;
    r.zero = 1'($urandom);
    return r;
  endfunction

  task automatic idle();
    cyc_t r;
    cur_ir = 32'h0;
    r = blank();
    q.push_back(r);
  endtask

  // Expand one instruction into its expected cycle sequence.
  task automatic gen(input logic [31:0] w, input int fw, input int mw,
                     input logic z, input int trap_n, input int abort_at);
    kind_e k;
    cyc_t  r;
    k = kind_of(w);
    for (int i = 0; i < fw; i++) begin
      r = blank(); r.rdy = 0; r.mr = 1; r.c_iord = 1; r.c_pc = 1;
      q.push_back(r);
    end
    r = blank(); r.rdy = 1; r.rdata = w; r.mr = 1; r.irw = 1;
    r.pcen = 1; r.c_iord = 1; r.c_pc = 1;
    q.push_back(r);
    cur_ir = w;
    r = blank();
    q.push_back(r);
    if (k == K_ILL) begin
      for (int i = 0; i < trap_n; i++) begin
        r = blank(); r.ill = 1; r.rst_after = (i == trap_n - 1);
        q.push_back(r);
      end
      idle();
      return;
    end
    r = blank(); r.c_alu = 1;
    case (k)
      K_ADD: r.aluop = 4'b0010;
      K_ADDI, K_LW, K_SW: begin r.alusrc = 1; r.aluop = 4'b0010; end
      K_BEQ, K_BNE: begin
        r.zero = z; r.aluop = 4'b0110; r.c_pc = 1; r.pcsrc = 2'b01;
        r.pcen = (k == K_BEQ) ? z : !z; r.ret = 1;
      end
      default: begin
        r.c_alu = 0; r.c_pc = 1; r.pcsrc = 2'b10; r.pcen = 1; r.ret = 1;
      end
    endcase
    q.push_back(r);
    if (k == K_LW || k == K_SW) begin
      for (int i = 0; i < mw; i++) begin
        r = blank(); r.rdy = 0; r.iord = 1; r.c_iord = 1;
        r.mr = (k == K_LW); r.mw = (k == K_SW);
        if (i == abort_at) begin
          r.rst_after = 1; q.push_back(r); idle(); return;
        end
        q.push_back(r);
      end
      r = blank(); r.rdy = 1; r.iord = 1; r.c_iord = 1;
      r.mr = (k == K_LW); r.mw = (k == K_SW); r.ret = (k == K_SW);
      q.push_back(r);
    end
    if (k == K_ADD || k == K_ADDI || k == K_LW) begin
      r = blank(); r.rw = 1; r.ret = 1; r.c_wb = 1;
      r.regdst = (k == K_ADD); r.m2r = (k == K_LW);
      q.push_back(r);
    end
  endtask

  function automatic logic [31:0] rand_legal();
    logic [31:0] w;
    logic [5:0]  ops [7];
    int          s;
    ops = '{6'd0, 6'd8, 6'd35, 6'd43, 6'd2, 6'd4, 6'd5};
    s = $urandom_range(0, 6);
    w = $urandom;
    w[31:26] = ops[s];
    if (s == 0) w[5:0] = 6'h20;
    return w;
  endfunction

  function automatic logic [31:0] rand_illegal();
    logic [31:0] w;
    w = 32'hFC000000;
    for (int i = 0; i < 100; i++) begin
      w = $urandom;
      if (i % 3 == 0) w[31:26] = 6'd0;
      if (kind_of(w) == K_ILL) break;
    end
    if (kind_of(w) != K_ILL) w = 32'hFC000000;
    return w;
  endfunction

  initial begin
    int   s;
    cyc_t r;
    logic [31:0] w;

    rst = 1'b1;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = 32'h0;
    bus.zero = 1'b0;

    idle();
    s = q.size(); gen(32'h00430820, 0, 0, 0, 0, -1);
    chk("len_add", q.size() - s, 4);
    chk("add_wb_regdst", {31'd0, q[q.size()-1].regdst}, 1);
    s = q.size(); gen(32'h8C410004, 0, 2, 0, 0, -1);
    chk("len_lw_2wait", q.size() - s, 7);
    s = q.size(); gen(32'h10220003, 0, 0, 1, 0, -1);
    chk("len_beq", q.size() - s, 3);
    gen(32'h10220003, 0, 0, 0, 0, -1);
    gen(32'h14220003, 0, 0, 1, 0, -1);
    gen(32'h14220003, 0, 0, 0, 0, -1);
    s = q.size(); gen(32'hAC410008, 2, 1, 0, 0, -1);
    chk("len_sw_fetchwait", q.size() - s, 7);
    s = q.size(); gen(32'h08000010, 0, 0, 0, 0, -1);
    chk("len_j", q.size() - s, 3);
    s = q.size(); gen(32'h20410005, 0, 0, 0, 0, -1);
    chk("len_addi", q.size() - s, 4);
    gen(32'hFC000000, 0, 0, 0, 22, -1);
    gen(32'h00430822, 1, 0, 0, 21, -1);
    gen(32'hAC410008, 0, 5, 0, 0, 1);

    for (int n = 0; n < 250; n++) begin
      int p;
      p = $urandom_range(0, 99);
      if (p < 6) begin
        gen(rand_illegal(), $urandom_range(0, 2), 0, 0,
            $urandom_range(20, 24), -1);
      end else if (p < 10) begin
        w = $urandom;
        w[31:26] = ($urandom_range(0, 1) == 1) ? 6'd43 : 6'd35;
        s = $urandom_range(1, 3);
        gen(w, $urandom_range(0, 2), s, 0, 0, $urandom_range(0, s - 1));
      end else begin
        gen(rand_legal(), $urandom_range(0, 3), $urandom_range(0, 3),
            1'($urandom), 0, -1);
      end
    end

    @(posedge clk);
    #1;
    chk("rst_ir", bus.ir, 0);
    chk("rst_memread", {31'd0, bus.MemRead}, 0);
    chk("rst_pcen", {31'd0, bus.PCen}, 0);
    chk("rst_retire", {31'd0, bus.retire}, 0);
    chk("rst_illegal", {31'd0, bus.illegal}, 0);
    @(posedge clk);
    #1 rst = 1'b0;

    while (q.size() > 0) begin
      r = q.pop_front();
      @(negedge clk);
      bus.mem_ready = r.rdy;
      bus.mem_rdata = r.rdata;
      bus.zero = r.zero;
      #2;
      chk("ir", bus.ir, r.ir);
      chk("MemRead", {31'd0, bus.MemRead}, {31'd0, r.mr});
      chk("MemWrite", {31'd0, bus.MemWrite}, {31'd0, r.mw});
      chk("IRWrite", {31'd0, bus.IRWrite}, {31'd0, r.irw});
      chk("PCen", {31'd0, bus.PCen}, {31'd0, r.pcen});
      chk("RegWrite", {31'd0, bus.RegWrite}, {31'd0, r.rw});
      chk("retire", {31'd0, bus.retire}, {31'd0, r.ret});
      chk("illegal", {31'd0, bus.illegal}, {31'd0, r.ill});
      if (r.c_iord) chk("IorD", {31'd0, bus.IorD}, {31'd0, r.iord});
      if (r.c_pc) chk("PCSrc", {30'd0, bus.PCSrc}, {30'd0, r.pcsrc});
      if (r.c_alu) begin
        chk("ALUSrc", {31'd0, bus.ALUSrc}, {31'd0, r.alusrc});
        chk("ALUOp", {28'd0, bus.ALUOp}, {28'd0, r.aluop});
      end
      if (r.c_wb) begin
        chk("RegDst", {31'd0, bus.RegDst}, {31'd0, r.regdst});
        chk("MemToReg", {31'd0, bus.MemToReg}, {31'd0, r.m2r});
      end
      chk("rd_wr_excl", {31'd0, bus.MemRead & bus.MemWrite}, 0);
      chk("rw_pc_excl", {31'd0, bus.RegWrite & bus.PCen}, 0);
      if (r.rst_after) begin
        #1 rst = 1'b1;
        #1;
        chk("arst_memwrite", {31'd0, bus.MemWrite}, 0);
        chk("arst_memread", {31'd0, bus.MemRead}, 0);
        chk("arst_retire", {31'd0, bus.retire}, 0);
        chk("arst_illegal", {31'd0, bus.illegal}, 0);
        chk("arst_ir", bus.ir, 0);
        @(posedge clk);
        #1 rst = 1'b0;
      end
      idx++;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
